// File: rtl/data_sync.sv
// data_sync: multi-bit CDC receiver capturing a quasi-static bus on the synchronised enable rising edge
module data_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_EN,
  input  logic                 OUT_READY,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 OUT_VALID,
  output logic                 OVERRUN,
  output logic [CNT_WIDTH-1:0] OVR_CNT
);
  typedef enum logic {EMPTY, FULL} state_t;
  logic [NUM_STAGES-1:0] r_sync;
  logic                  r_en_q;
  state_t                r_state;
  state_t                w_next;
  logic                  w_cap;
  logic                  w_ovr;
  assign w_cap = r_sync[NUM_STAGES-1] & ~r_en_q;
  assign w_ovr = w_cap & (r_state == FULL) & ~OUT_READY;
  // enable synchroniser chain plus delayed copy for rising-edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync <= '0;
      r_en_q <= 1'b0;
    end else begin
      r_sync <= {r_sync[NUM_STAGES-2:0], BUS_EN};
      r_en_q <= r_sync[NUM_STAGES-1];
    end
  end
  // handshake state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= EMPTY;
    else      r_state <= w_next;
  end
  // next state: a capture always leaves a word held; otherwise a ready consumer drains it
  always_comb begin
    w_next = (r_state == EMPTY) ? (w_cap ? FULL : EMPTY) : ((w_cap || !OUT_READY) ? FULL : EMPTY);
  end
  // handshake output decode
  always_comb begin
    OUT_VALID = (r_state == FULL);
  end
  // data capture only on the detected edge, plus overrun strobe and saturating count
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SYNC_BUS     <= '0;
      ENABLE_PULSE <= 1'b0;
      OVERRUN      <= 1'b0;
      OVR_CNT      <= '0;
    end else begin
      if (w_cap) SYNC_BUS <= UNSYNC_BUS;
      ENABLE_PULSE <= w_cap;
      OVERRUN      <= w_ovr;
      if (w_ovr && !(&OVR_CNT)) OVR_CNT <= OVR_CNT + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: randomized and directed checks of data_sync against a history-based reference model
module tb_data_sync;
  localparam int N = 2;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] UNSYNC_BUS = '0;
  logic       BUS_EN = 1'b0;
  logic       OUT_READY = 1'b0;
  logic [7:0] sync_a, sync_b;
  logic       pulse_a, pulse_b, valid_a, valid_b, ovr_a, ovr_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  int ovrs = 0;
  bit chk_on = 0;
  bit hist[$];
  bit m_pulse, m_valid, m_ovr;
  logic [7:0] m_data;
  int m_n;
  always #5 CLK = ~CLK;
  data_sync u_dut (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_EN(BUS_EN), .OUT_READY(OUT_READY),
    .SYNC_BUS(sync_a), .ENABLE_PULSE(pulse_a), .OUT_VALID(valid_a), .OVERRUN(ovr_a), .OVR_CNT(cnt_a)
  );
  data_sync #(.NUM_STAGES(N), .BUS_WIDTH(8), .CNT_WIDTH(2)) u_dut_c2 (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_EN(BUS_EN), .OUT_READY(OUT_READY),
    .SYNC_BUS(sync_b), .ENABLE_PULSE(pulse_b), .OUT_VALID(valid_b), .OVERRUN(ovr_b), .OVR_CNT(cnt_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // reference: a capture happens at edge m when BUS_EN was sampled low at m-N-1 and high at m-N
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hist.delete();
      for (int i = 0; i <= N; i++) hist.push_back(1'b0);
      m_pulse = 0; m_valid = 0; m_ovr = 0; m_data = '0; m_n = 0;
    end else begin
      bit cap;
      hist.push_back(BUS_EN);
      cap = hist[hist.size()-1-N] && !hist[hist.size()-2-N];
      if (hist.size() > 16) void'(hist.pop_front());
      m_ovr = cap && m_valid && !OUT_READY;
      if (m_ovr) m_n++;
      m_pulse = cap;
      if (cap) m_data = UNSYNC_BUS;
      m_valid = cap ? 1'b1 : (m_valid && !OUT_READY);
    end
  end
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("sync_bus", sync_a, m_data);
      chk("enable_pulse", pulse_a, m_pulse);
      chk("out_valid", valid_a, m_valid);
      chk("overrun", ovr_a, m_ovr);
      chk("ovr_cnt", cnt_a, (m_n > 255) ? 255 : m_n);
      chk("c2_sync_bus", sync_b, m_data);
      chk("c2_overrun", ovr_b, m_ovr);
      chk("c2_ovr_cnt", cnt_b, (m_n > 3) ? 3 : m_n);
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      pulses += pulse_a;
      ovrs += ovr_a;
    end
  endtask
  task automatic send(input logic [7:0] d, input int hi, input int lo);
    UNSYNC_BUS = d;
    BUS_EN = 1'b1;
    cyc(hi);
    BUS_EN = 1'b0;
    cyc(lo);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_sync"}, {sync_a, sync_b}, 16'h0);
    chk({tag, "_flags"}, {pulse_a, valid_a, ovr_a, pulse_b, valid_b, ovr_b}, 6'h0);
    chk({tag, "_cnt"}, {cnt_a, cnt_b}, 10'h0);
  endtask
  initial begin
    logic [7:0] cnt_before;
    cyc(2);
    chk_zero("reset");
    chk_on = 1;
    RST = 1'b1;
    // single word, consumer ready
    OUT_READY = 1'b1;
    UNSYNC_BUS = 8'hA5;
    BUS_EN = 1'b1;
    pulses = 0;
    cyc(2);
    chk("t1_no_early_pulse", pulse_a, 1'b0);
    cyc(1);
    chk("t1_pulse_edge3", pulse_a, 1'b1);
    chk("t1_data", sync_a, 8'hA5);
    chk("t1_valid", valid_a, 1'b1);
    cyc(1);
    chk("t1_valid_drop", valid_a, 1'b0);
    cyc(1);
    BUS_EN = 1'b0;
    cyc(4);
    chk("t1_pulses", pulses, 1);
    chk("t1_cnt", cnt_a, 8'h0);
    // long enable level, bus changes after capture
    pulses = 0;
    UNSYNC_BUS = 8'h3C;
    BUS_EN = 1'b1;
    cyc(4);
    UNSYNC_BUS = 8'hC3;
    cyc(16);
    BUS_EN = 1'b0;
    cyc(4);
    chk("t2_pulses", pulses, 1);
    chk("t2_hold", sync_a, 8'h3C);
    // overwrite while consumer stalled
    OUT_READY = 1'b0;
    ovrs = 0;
    send(8'h11, 3, 3);
    send(8'h22, 3, 3);
    chk("t3_data", sync_a, 8'h22);
    chk("t3_valid", valid_a, 1'b1);
    chk("t3_ovrs", ovrs, 1);
    chk("t3_cnt", cnt_a, 8'd1);
    OUT_READY = 1'b1;
    cyc(1);
    OUT_READY = 1'b0;
    chk("t3_drain", valid_a, 1'b0);
    // ready coincident with the second capture: replace without overrun
    send(8'h44, 3, 3);
    cnt_before = cnt_a;
    UNSYNC_BUS = 8'h55;
    BUS_EN = 1'b1;
    cyc(2);
    OUT_READY = 1'b1;
    cyc(1);
    OUT_READY = 1'b0;
    chk("t4_valid", valid_a, 1'b1);
    chk("t4_data", sync_a, 8'h55);
    chk("t4_no_ovr", ovr_a, 1'b0);
    chk("t4_cnt", cnt_a, cnt_before);
    BUS_EN = 1'b0;
    cyc(2);
    OUT_READY = 1'b1;
    cyc(1);
    OUT_READY = 1'b0;
    // saturation of the narrow counter
    ovrs = 0;
    for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 3, 1);
    cyc(3);
    chk("t5_ovrs", ovrs, 4);
    chk("t5_c2_sat", cnt_b, 2'd3);
    chk("t5_wide_cnt", cnt_a, 8'd5);
    OUT_READY = 1'b1;
    cyc(1);
    // reset one cycle after enable rises
    UNSYNC_BUS = 8'h9E;
    BUS_EN = 1'b1;
    @(posedge CLK);
    #2 RST = 1'b0;
    #1 chk_zero("t6_async");
    cyc(2);
    chk_zero("t6_held");
    RST = 1'b1;
    pulses = 0;
    cyc(2);
    chk("t6_no_early", pulse_a, 1'b0);
    cyc(1);
    chk("t6_pulse", pulse_a, 1'b1);
    chk("t6_data", sync_a, 8'h9E);
    cyc(5);
    chk("t6_pulses", pulses, 1);
    BUS_EN = 1'b0;
    cyc(3);
    // randomized traffic
    for (int w = 0; w < 300; w++) begin
      int hi;
      int lo;
      hi = $urandom_range(N + 4, N + 1);
      lo = $urandom_range(4, 1);
      UNSYNC_BUS = 8'($urandom);
      BUS_EN = 1'b1;
      for (int c = 0; c < hi; c++) begin
        OUT_READY = 1'($urandom);
        if (c > N + 1 && $urandom_range(1, 0) == 1) UNSYNC_BUS = 8'($urandom);
        cyc(1);
      end
      BUS_EN = 1'b0;
      for (int c = 0; c < lo; c++) begin
        OUT_READY = 1'($urandom);
        cyc(1);
      end
    end
    cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
